ei_axi4_slave_mem: RTL and testbench

//  Synthesizable AXI4 slave memory. It is the DUT that ei_axi4_interface connects to, so the VIP master drives it and the monitor/checker observes it.

---
 rtl/ei_axi4_slave_mem.sv | 260 ++++++++++++++++++++++++++
 tb/tb_ei_axi4_slave_mem.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ei_axi4_slave_mem.sv
// ei_axi4_slave_mem
//   AXI4 slave memory. It accepts FIXED, INCR and WRAP bursts on independent
//   write and read paths, with one outstanding transaction per path. Every
//   beat is the full bus width. There is no AxSIZE and no ID.
//   Illegal bursts are executed as INCR and reported as SLVERR. An illegal
//   burst is AxBURST=11, or WRAP with a length other than 2/4/8/16.
//   Beats whose word index falls outside the array are also reported as
//   SLVERR: they are discarded on writes and read back as zero.
//
// Ports
//   aclk, areset             clock; asynchronous active-high reset
//   aw* (addr/len/burst)     write address channel (valid/ready)
//   w*  (data/strb/last)     write data channel (valid/ready)
//   b*  (resp)               write response channel (valid/ready)
//   ar* (addr/len/burst)     read address channel (valid/ready)
//   r*  (data/resp/last)     read data channel (valid/ready)
module ei_axi4_slave_mem #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 16,
    parameter int MEM_DEPTH = 1024
) (
    input  logic                aclk,
    input  logic                areset,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic [7:0]          awlen,
    input  logic [1:0]          awburst,
    input  logic                awvalid,
    output logic                awready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wlast,
    input  logic                wvalid,
    output logic                wready,
    output logic [1:0]          bresp,
    output logic                bvalid,
    input  logic                bready,
    input  logic [ADDR_W-1:0]   araddr,
    input  logic [7:0]          arlen,
    input  logic [1:0]          arburst,
    input  logic                arvalid,
    output logic                arready,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp,
    output logic                rlast,
    output logic                rvalid,
    input  logic                rready
);
    localparam int STRB_W     = DATA_W / 8;
    localparam int BYTE_SHIFT = $clog2(STRB_W);
    localparam int MEM_AW     = $clog2(MEM_DEPTH);

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    function automatic logic illegal_burst(input logic [1:0] burst, input logic [7:0] len);
        return (burst == 2'b11) ||
               ((burst == BURST_WRAP) &&
                !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
    endfunction

    function automatic logic [1:0] eff_burst(input logic [1:0] burst, input logic [7:0] len);
        if (illegal_burst(burst, len)) return BURST_INCR;
        return burst;
    endfunction

    // A WRAP container is a power of two bytes, so wrapping just keeps the
    // base bits of the current address and lets the offset bits roll over.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                    input logic [7:0]        len,
                                                    input logic [1:0]        burst);
        logic [ADDR_W-1:0] step;
        logic [ADDR_W-1:0] span_mask;
        step      = addr + ADDR_W'(STRB_W);
        span_mask = ((ADDR_W'(len) + ADDR_W'(1)) << BYTE_SHIFT) - ADDR_W'(1);
        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_WRAP:  next_addr = (addr & ~span_mask) | (step & span_mask);
            default:     next_addr = step;
        endcase
    endfunction

    function automatic logic in_range(input logic [ADDR_W-1:0] addr);
        return (addr >> BYTE_SHIFT) < ADDR_W'(MEM_DEPTH);
    endfunction

    function automatic logic [MEM_AW-1:0] word_idx(input logic [ADDR_W-1:0] addr);
        return MEM_AW'(addr >> BYTE_SHIFT);
    endfunction

    logic        ready_en;
    w_state_t    w_state, w_state_nxt;
    logic [ADDR_W-1:0] w_addr;
    logic [7:0]  w_len, w_beat;
    logic [1:0]  w_burst;
    logic        w_err;
    logic        aw_fire, w_fire;

    r_state_t    r_state, r_state_nxt;
    logic [ADDR_W-1:0] r_addr, fetch_addr;
    logic [7:0]  r_len, r_beat;
    logic [1:0]  r_burst;
    logic        r_bad, fetch_bad, fetch_last;
    logic        ar_fire, r_adv;

    assign aw_fire = awvalid && awready;
    assign w_fire  = wvalid && wready;
    assign ar_fire = arvalid && arready;
    assign r_adv   = rvalid && rready && !rlast;

    // The ready outputs must stay low while reset is held. This flag rises on
    // the first clock edge after release and enables the idle-state readies.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) ready_en <= 1'b0;
        else        ready_en <= 1'b1;
    end

    // Write FSM state register.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) w_state <= W_IDLE;
        else        w_state <= w_state_nxt;
    end

    // Write FSM next state and channel handshake outputs.
    always_comb begin
        w_state_nxt = w_state;
        awready     = 1'b0;
        wready      = 1'b0;
        bvalid      = 1'b0;
        bresp       = RESP_OKAY;
        case (w_state)
            W_IDLE: begin
                awready = ready_en;
                if (awvalid && ready_en) w_state_nxt = W_DATA;
            end
            W_DATA: begin
                wready = 1'b1;
                if (wvalid && (w_beat == w_len)) w_state_nxt = W_RESP;
            end
            W_RESP: begin
                bvalid = 1'b1;
                bresp  = w_err ? RESP_SLVERR : RESP_OKAY;
                if (bready) w_state_nxt = W_IDLE;
            end
            default: w_state_nxt = W_IDLE;
        endcase
    end

    // Write burst bookkeeping. The error flag collects every problem seen
    // during the burst and is reported once, on B.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            w_addr  <= '0;
            w_len   <= '0;
            w_burst <= BURST_FIXED;
            w_beat  <= '0;
            w_err   <= 1'b0;
        end else if (aw_fire) begin
            w_addr  <= awaddr;
            w_len   <= awlen;
            w_burst <= eff_burst(awburst, awlen);
            w_beat  <= '0;
            w_err   <= illegal_burst(awburst, awlen);
        end else if (w_fire) begin
            w_addr <= next_addr(w_addr, w_len, w_burst);
            w_beat <= w_beat + 8'd1;
            if ((wlast != (w_beat == w_len)) || !in_range(w_addr)) w_err <= 1'b1;
        end
    end

    // Byte-enabled write into the array. Out-of-range beats are dropped.
    // The array is not reset.
    always_ff @(posedge aclk) begin
        if (w_fire && in_range(w_addr)) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb[b]) mem[word_idx(w_addr)][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    // Read FSM state register.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) r_state <= R_IDLE;
        else        r_state <= r_state_nxt;
    end

    // Read FSM next state and handshake outputs.
    always_comb begin
        r_state_nxt = r_state;
        arready     = 1'b0;
        rvalid      = 1'b0;
        case (r_state)
            R_IDLE: begin
                arready = ready_en;
                if (arvalid && ready_en) r_state_nxt = R_DATA;
            end
            R_DATA: begin
                rvalid = 1'b1;
                if (rready && rlast) r_state_nxt = R_IDLE;
            end
            default: r_state_nxt = R_IDLE;
        endcase
    end

    // Selects the beat to be registered next. On AR acceptance the request
    // comes straight from the AR inputs, which gives the one-cycle latency.
    // Otherwise it is the beat that follows the one now on the bus.
    always_comb begin
        fetch_addr = next_addr(r_addr, r_len, r_burst);
        fetch_bad  = r_bad;
        fetch_last = ((r_beat + 8'd1) == r_len);
        if (ar_fire) begin
            fetch_addr = araddr;
            fetch_bad  = illegal_burst(arburst, arlen);
            fetch_last = (arlen == 8'd0);
        end
    end

    // Registered R channel. Outputs only change when a new beat is loaded,
    // so they hold steady while the master stalls.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_addr  <= '0;
            r_len   <= '0;
            r_burst <= BURST_FIXED;
            r_beat  <= '0;
            r_bad   <= 1'b0;
            rdata   <= '0;
            rresp   <= RESP_OKAY;
            rlast   <= 1'b0;
        end else if (ar_fire || r_adv) begin
            r_addr <= fetch_addr;
            rlast  <= fetch_last;
            if (ar_fire) begin
                r_len   <= arlen;
                r_burst <= eff_burst(arburst, arlen);
                r_bad   <= illegal_burst(arburst, arlen);
                r_beat  <= '0;
            end else begin
                r_beat <= r_beat + 8'd1;
            end
            if (in_range(fetch_addr)) begin
                rdata <= mem[word_idx(fetch_addr)];
                rresp <= fetch_bad ? RESP_SLVERR : RESP_OKAY;
            end else begin
                rdata <= '0;
                rresp <= RESP_SLVERR;
            end
        end else if (rvalid && rready) begin
            rlast <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ei_axi4_slave_mem.sv
module tb_ei_axi4_slave_mem;
    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 16;
    localparam int MEM_DEPTH = 1024;
    localparam int TMO       = 50;

    logic              aclk = 1'b0;
    logic              areset;
    logic [ADDR_W-1:0] awaddr, araddr;
    logic [7:0]        awlen, arlen;
    logic [1:0]        awburst, arburst;
    logic              awvalid, awready, wlast, wvalid, wready;
    logic [DATA_W-1:0] wdata, rdata;
    logic [3:0]        wstrb;
    logic [1:0]        bresp, rresp;
    logic              bvalid, bready, arvalid, arready, rlast, rvalid, rready;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [15:0]      addr;
        logic [7:0]       len;
        logic [1:0]       burst;
        logic [3:0]       strb;
        logic [3:0][31:0] data;
        logic [7:0]       wlast_at;
        logic [1:0]       exp_bresp;
    } wr_vec_t;

    typedef struct packed {
        logic [15:0]      addr;
        logic [7:0]       len;
        logic [1:0]       burst;
        logic [3:0][31:0] exp_data;
        logic [3:0][1:0]  exp_resp;
    } rd_vec_t;

    wr_vec_t wr_tab [8];
    rd_vec_t rd_tab [9];

    ei_axi4_slave_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_DEPTH(MEM_DEPTH)) dut (
        .aclk(aclk), .areset(areset),
        .awaddr(awaddr), .awlen(awlen), .awburst(awburst), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arlen(arlen), .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    always #5 aclk = ~aclk;

    function automatic logic [3:0][31:0] mk4(input logic [31:0] d0, input logic [31:0] d1,
                                             input logic [31:0] d2, input logic [31:0] d3);
        logic [3:0][31:0] r;
        r[0] = d0; r[1] = d1; r[2] = d2; r[3] = d3;
        return r;
    endfunction

    function automatic logic [3:0][1:0] mkr(input logic [1:0] r0, input logic [1:0] r1,
                                            input logic [1:0] r2, input logic [1:0] r3);
        logic [3:0][1:0] r;
        r[0] = r0; r[1] = r1; r[2] = r2; r[3] = r3;
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_bad++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    function automatic logic pick(input int which);
        case (which)
            0:       return awready;
            1:       return wready;
            2:       return bvalid;
            3:       return arready;
            default: return rvalid;
        endcase
    endfunction

    // Waits at negedges until the chosen signal is high, or gives up after TMO.
    task automatic waitReady(input int which, input string name);
        int n = 0;
        while (pick(which) !== 1'b1 && n < TMO) begin
            @(negedge aclk);
            n++;
        end
        checkOutput({name, "_seen"}, 32'(pick(which)), 32'd1);
    endtask

    // Drives AW and all W beats of one write burst; leaves B pending.
    task automatic applyStimulus(input wr_vec_t v);
        @(negedge aclk);
        awaddr = v.addr; awlen = v.len; awburst = v.burst; awvalid = 1'b1;
        waitReady(0, "awready");
        @(negedge aclk);
        awvalid = 1'b0;
        for (int i = 0; i <= int'(v.len); i++) begin
            wdata = v.data[i]; wstrb = v.strb; wlast = (8'(i) == v.wlast_at); wvalid = 1'b1;
            waitReady(1, "wready");
            @(negedge aclk);
        end
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic finishWrite(input string tag, input logic [1:0] exp);
        bready = 1'b1;
        waitReady(2, "bvalid");
        checkOutput({tag, "_bresp"}, 32'(bresp), 32'(exp));
        @(negedge aclk);
        bready = 1'b0;
        checkOutput({tag, "_bvalid_drop"}, 32'(bvalid), 32'd0);
    endtask

    task automatic collectRead(input rd_vec_t v, input string tag);
        @(negedge aclk);
        araddr = v.addr; arlen = v.len; arburst = v.burst; arvalid = 1'b1;
        waitReady(3, "arready");
        @(negedge aclk);
        arvalid = 1'b0; rready = 1'b1;
        for (int i = 0; i <= int'(v.len); i++) begin
            waitReady(4, "rvalid");
            checkOutput($sformatf("%s_rdata%0d", tag, i), rdata, v.exp_data[i]);
            checkOutput($sformatf("%s_rresp%0d", tag, i), 32'(rresp), 32'(v.exp_resp[i]));
            checkOutput($sformatf("%s_rlast%0d", tag, i), 32'(rlast), 32'(i == int'(v.len)));
            @(negedge aclk);
        end
        rready = 1'b0;
        checkOutput({tag, "_rvalid_drop"}, 32'(rvalid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        // Write table: addr, len, burst, strb, data, wlast beat, expected bresp
        wr_tab[0] = '{16'h0010, 8'd3, 2'b01, 4'hF, mk4(32'hA0, 32'hA1, 32'hA2, 32'hA3), 8'd3, 2'b00};
        wr_tab[1] = '{16'h0000, 8'd3, 2'b01, 4'hF, mk4(32'h0, 32'h1, 32'h2, 32'h3), 8'd3, 2'b00};
        wr_tab[2] = '{16'h0020, 8'd0, 2'b01, 4'hF, mk4(32'hFFFFFFFF, 0, 0, 0), 8'd0, 2'b00};
        wr_tab[3] = '{16'h0020, 8'd0, 2'b01, 4'h3, mk4(32'h11223344, 0, 0, 0), 8'd0, 2'b00};
        wr_tab[4] = '{16'h0040, 8'd2, 2'b00, 4'hF, mk4(32'h5, 32'h6, 32'h7, 0), 8'd2, 2'b00};
        wr_tab[5] = '{16'h0050, 8'd2, 2'b10, 4'hF, mk4(32'hB0, 32'hB1, 32'hB2, 0), 8'd2, 2'b10};
        wr_tab[6] = '{16'h0FFC, 8'd1, 2'b01, 4'hF, mk4(32'hD0, 32'hD1, 0, 0), 8'd1, 2'b10};
        wr_tab[7] = '{16'h0070, 8'd1, 2'b11, 4'hF, mk4(32'hE0, 32'hE1, 0, 0), 8'd1, 2'b10};
        // Read table: addr, len, burst, expected data, expected per-beat resp
        rd_tab[0] = '{16'h0010, 8'd3, 2'b01, mk4(32'hA0, 32'hA1, 32'hA2, 32'hA3), mkr(0, 0, 0, 0)};
        rd_tab[1] = '{16'h0008, 8'd3, 2'b10, mk4(32'h2, 32'h3, 32'h0, 32'h1), mkr(0, 0, 0, 0)};
        rd_tab[2] = '{16'h0020, 8'd0, 2'b01, mk4(32'hFFFF3344, 0, 0, 0), mkr(0, 0, 0, 0)};
        rd_tab[3] = '{16'h0040, 8'd1, 2'b00, mk4(32'h7, 32'h7, 0, 0), mkr(0, 0, 0, 0)};
        rd_tab[4] = '{16'h0050, 8'd2, 2'b01, mk4(32'hB0, 32'hB1, 32'hB2, 0), mkr(0, 0, 0, 0)};
        rd_tab[5] = '{16'h0010, 8'd1, 2'b11, mk4(32'hA0, 32'hA1, 0, 0), mkr(2, 2, 0, 0)};
        rd_tab[6] = '{16'h0014, 8'd1, 2'b10, mk4(32'hA1, 32'hA0, 0, 0), mkr(0, 0, 0, 0)};
        rd_tab[7] = '{16'h0FFC, 8'd1, 2'b01, mk4(32'hD0, 32'h0, 0, 0), mkr(0, 2, 0, 0)};
        rd_tab[8] = '{16'h0070, 8'd1, 2'b01, mk4(32'hE0, 32'hE1, 0, 0), mkr(0, 0, 0, 0)};

        areset = 1'b1;
        awaddr = '0; awlen = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arlen = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;

        // Reset state
        @(negedge aclk);
        @(negedge aclk);
        checkOutput("rst_awready", 32'(awready), 0);
        checkOutput("rst_arready", 32'(arready), 0);
        checkOutput("rst_wready", 32'(wready), 0);
        checkOutput("rst_bvalid", 32'(bvalid), 0);
        checkOutput("rst_rvalid", 32'(rvalid), 0);
        checkOutput("rst_rlast", 32'(rlast), 0);
        checkOutput("rst_rdata", rdata, 0);
        areset = 1'b0;
        @(negedge aclk);
        checkOutput("rel_awready", 32'(awready), 1);
        checkOutput("rel_arready", 32'(arready), 1);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(wr_tab[i]);
            finishWrite($sformatf("wr%0d", i), wr_tab[i].exp_bresp);
        end
        for (int i = 0; i < 9; i++) collectRead(rd_tab[i], $sformatf("rd%0d", i));

        // Bad wlast position with a stalled B channel
        applyStimulus('{16'h0060, 8'd3, 2'b01, 4'hF, mk4(32'hC0, 32'hC1, 32'hC2, 32'hC3), 8'd1, 2'b10});
        bready = 1'b0;
        waitReady(2, "wlast_bvalid");
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("bstall_bvalid%0d", i), 32'(bvalid), 1);
            checkOutput($sformatf("bstall_bresp%0d", i), 32'(bresp), 32'h2);
            @(negedge aclk);
        end
        finishWrite("bstall", 2'b10);
        collectRead('{16'h0060, 8'd3, 2'b01, mk4(32'hC0, 32'hC1, 32'hC2, 32'hC3), mkr(0, 0, 0, 0)}, "wlast_rb");

        // Out-of-range single read with R stalled for 5 cycles
        @(negedge aclk);
        araddr = 16'h1000; arlen = 8'd0; arburst = 2'b01; arvalid = 1'b1;
        waitReady(3, "oor_arready");
        @(negedge aclk);
        arvalid = 1'b0; rready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("rstall_rvalid%0d", i), 32'(rvalid), 1);
            checkOutput($sformatf("rstall_rdata%0d", i), rdata, 0);
            checkOutput($sformatf("rstall_rresp%0d", i), 32'(rresp), 32'h2);
            checkOutput($sformatf("rstall_rlast%0d", i), 32'(rlast), 1);
            @(negedge aclk);
        end
        rready = 1'b1;
        @(negedge aclk);
        rready = 1'b0;
        checkOutput("rstall_rvalid_drop", 32'(rvalid), 0);

        // Reset in the middle of an 8-beat read
        @(negedge aclk);
        araddr = 16'h0000; arlen = 8'd7; arburst = 2'b01; arvalid = 1'b1;
        waitReady(3, "mid_arready");
        @(negedge aclk);
        arvalid = 1'b0; rready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("mid_rvalid%0d", i), 32'(rvalid), 1);
            checkOutput($sformatf("mid_rdata%0d", i), rdata, 32'(i));
            if (i < 2) @(negedge aclk);
        end
        #2 areset = 1'b1;
        #1;
        checkOutput("mid_rst_rvalid", 32'(rvalid), 0);
        checkOutput("mid_rst_arready", 32'(arready), 0);
        checkOutput("mid_rst_awready", 32'(awready), 0);
        rready = 1'b0;
        @(negedge aclk);
        areset = 1'b0;
        @(negedge aclk);
        checkOutput("mid_rel_arready", 32'(arready), 1);
        collectRead('{16'h0010, 8'd0, 2'b01, mk4(32'hA0, 0, 0, 0), mkr(0, 0, 0, 0)}, "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
